// File: rtl/xoro_rand_gen_stage_if.sv
// Request/response bundle for one xoroshiro128+ stage: seeds and request in,
// output word, valid pulse and exported state out.
interface xoro_rand_gen_stage_if #(
    parameter int BIT_WIDTH = 64
) ();
    logic [BIT_WIDTH-1:0] s0_initial;
    logic [BIT_WIDTH-1:0] s1_initial;
    logic                 next_u64;
    logic [BIT_WIDTH-1:0] r;
    logic                 valid;
    logic [BIT_WIDTH-1:0] s0_new;
    logic [BIT_WIDTH-1:0] s1_new;

    modport master (
        output s0_initial, s1_initial, next_u64,
        input  r, valid, s0_new, s1_new
    );

    modport slave (
        input  s0_initial, s1_initial, next_u64,
        output r, valid, s0_new, s1_new
    );
endinterface

// File: rtl/xoro_rand_gen_stage.sv
// Single xoroshiro128+ stage: loads its seeds on the first edge after reset,
// then emits one 64-bit word per request. Optional macro: RAND_GEN_ZERO_SEED_GUARD_EN.
module xoro_rand_gen_stage #(
    parameter int BIT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    xoro_rand_gen_stage_if.slave  bus
);
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [BIT_WIDTH-1:0] word_t;

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (BIT_WIDTH - n));
    endfunction

    state_e state_q, state_d;
    word_t  s0_q, s0_d;
    word_t  s1_q, s1_d;
    word_t  r_q, r_d;
    logic   valid_q, valid_d;
    word_t  t;

    // NOTE: every variable gets a default before any branch, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        r_d     = r_q;
        valid_d = 1'b0;
        t       = s1_q ^ s0_q;

        unique case (state_q)
            ST_LOAD: begin
                // The load edge never counts as a request.
                state_d = ST_RUN;
                s0_d    = bus.s0_initial;
                s1_d    = bus.s1_initial;
`ifdef RAND_GEN_ZERO_SEED_GUARD_EN
                if (bus.s0_initial == '0 && bus.s1_initial == '0) begin
                    s1_d = word_t'(1);
                end
`endif
            end
            ST_RUN: begin
                if (bus.next_u64) begin
                    r_d     = s0_q + s1_q;
                    s0_d    = rotl(s0_q, 24) ^ t ^ (t << 16);
                    s1_d    = rotl(t, 37);
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            s0_q    <= '0;
            s1_q    <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            r_q     <= r_d;
            valid_q <= valid_d;
        end
    end

    assign bus.r      = r_q;
    assign bus.valid  = valid_q;
    assign bus.s0_new = s0_q;
    assign bus.s1_new = s1_q;
endmodule

// File: tb/tb_xoro_rand_gen_stage.sv
// Directed bench for xoro_rand_gen_stage: reset, single and spaced requests,
// back-to-back requests, load-edge request, mid-run reset and all-zero seeds.
module tb_xoro_rand_gen_stage;
    localparam logic [63:0] SEED0   = 64'd7646591175198567294;
    localparam logic [63:0] SEED1   = 64'd15909465551595111888;
    localparam logic [63:0] FIRST_R = 64'd5109312653084127566;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] m0, m1;

    xoro_rand_gen_stage_if #(.BIT_WIDTH(64)) bus ();

    xoro_rand_gen_stage #(.BIT_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference xoroshiro128+ step on m0/m1, rotations written as bit slices.
    function automatic logic [63:0] model_next();
        logic [63:0] w, t;
        w  = m0 + m1;
        t  = m0 ^ m1;
        m0 = {m0[39:0], m0[63:40]} ^ t ^ {t[47:0], 16'h0000};
        m1 = {t[26:0], t[63:27]};
        return w;
    endfunction

    task automatic hold_reset(input logic [63:0] a, input logic [63:0] b);
        bus.s0_initial = a;
        bus.s1_initial = b;
        bus.next_u64   = 1'b0;
        reset          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_and_load();
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic request();
        bus.next_u64 = 1'b1;
        @(posedge clk);
        #1;
        bus.next_u64 = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset(SEED0, SEED1);
        checks++; if (bus.r !== 64'd0) begin errors++; $display("FAIL reset_r got=%h exp=0", bus.r); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.s0_new !== 64'd0) begin errors++; $display("FAIL reset_s0 got=%h exp=0", bus.s0_new); end
        checks++; if (bus.s1_new !== 64'd0) begin errors++; $display("FAIL reset_s1 got=%h exp=0", bus.s1_new); end
        release_and_load();
        checks++; if (bus.s0_new !== SEED0) begin errors++; $display("FAIL load_s0 got=%h exp=%h", bus.s0_new, SEED0); end
        checks++; if (bus.s1_new !== SEED1) begin errors++; $display("FAIL load_s1 got=%h exp=%h", bus.s1_new, SEED1); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL load_valid got=%b exp=0", bus.valid); end
        m0 = SEED0;
        m1 = SEED1;
    endtask

    task automatic test_single_pulse();
        logic [63:0] w;
        request();
        w = model_next();
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.valid); end
        checks++; if (bus.r !== FIRST_R) begin errors++; $display("FAIL single_r got=%0d exp=%0d", bus.r, FIRST_R); end
        checks++; if (w !== FIRST_R) begin errors++; $display("FAIL model_first got=%0d exp=%0d", w, FIRST_R); end
        checks++; if (bus.s0_new !== m0 || bus.s1_new !== m1) begin
            errors++; $display("FAIL single_state got=%h/%h exp=%h/%h", bus.s0_new, bus.s1_new, m0, m1);
        end
        @(posedge clk); #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", bus.valid); end
        checks++; if (bus.r !== FIRST_R) begin errors++; $display("FAIL single_hold got=%0d exp=%0d", bus.r, FIRST_R); end
    endtask

    task automatic test_spaced_pulses();
        int pulses = 0;
        logic [63:0] w;
        for (int p = 0; p < 10; p++) begin
            request();
            w = model_next();
            if (bus.valid === 1'b1) pulses++;
            checks++; if (bus.r !== w) begin errors++; $display("FAIL spaced_r[%0d] got=%h exp=%h", p, bus.r, w); end
            for (int k = 1; k < 10; k++) begin
                @(posedge clk); #1;
                if (bus.valid === 1'b1) pulses++;
            end
            checks++; if (bus.r !== w) begin errors++; $display("FAIL spaced_hold[%0d] got=%h exp=%h", p, bus.r, w); end
        end
        checks++; if (pulses != 10) begin errors++; $display("FAIL spaced_pulse_count got=%0d exp=10", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_w [4];
        m0 = SEED0;
        m1 = SEED1;
        for (int i = 0; i < 4; i++) exp_w[i] = model_next();

        hold_reset(SEED0, SEED1);
        release_and_load();
        bus.next_u64 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) bus.next_u64 = 1'b0;
            checks++; if (bus.valid !== 1'b1 || bus.r !== exp_w[i]) begin
                errors++; $display("FAIL b2b[%0d] valid=%b r=%h exp_r=%h", i, bus.valid, bus.r, exp_w[i]);
            end
        end
        @(posedge clk); #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", bus.valid); end

        hold_reset(SEED0, SEED1);
        release_and_load();
        for (int i = 0; i < 4; i++) begin
            request();
            checks++; if (bus.valid !== 1'b1 || bus.r !== exp_w[i]) begin
                errors++; $display("FAIL spaced4[%0d] valid=%b r=%h exp_r=%h", i, bus.valid, bus.r, exp_w[i]);
            end
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_edge_request();
        hold_reset(SEED0, SEED1);
        bus.next_u64 = 1'b1;
        release_and_load();
        bus.next_u64 = 1'b0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL load_edge_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.s0_new !== SEED0 || bus.s1_new !== SEED1) begin
            errors++; $display("FAIL load_edge_state got=%h/%h exp=%h/%h", bus.s0_new, bus.s1_new, SEED0, SEED1);
        end
        request();
        checks++; if (bus.r !== FIRST_R) begin errors++; $display("FAIL load_edge_first got=%0d exp=%0d", bus.r, FIRST_R); end
    endtask

    task automatic test_reset_restart();
        hold_reset(SEED0, SEED1);
        release_and_load();
        repeat (3) request();
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL restart_pre_valid got=%b exp=1", bus.valid); end
        reset = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0 || bus.r !== 64'd0) begin
            errors++; $display("FAIL restart_async valid=%b r=%h exp valid=0 r=0", bus.valid, bus.r);
        end
        @(posedge clk); #1;
        release_and_load();
        request();
        checks++; if (bus.valid !== 1'b1 || bus.r !== FIRST_R) begin
            errors++; $display("FAIL restart_first valid=%b r=%0d exp=%0d", bus.valid, bus.r, FIRST_R);
        end
    endtask

    task automatic test_zero_seed();
        logic [63:0] w;
        m0 = 64'd0;
`ifdef RAND_GEN_ZERO_SEED_GUARD_EN
        m1 = 64'd1;
`else
        m1 = 64'd0;
`endif
        hold_reset(64'd0, 64'd0);
        release_and_load();
        request();
`ifdef RAND_GEN_ZERO_SEED_GUARD_EN
        checks++; if (bus.r !== 64'd1) begin errors++; $display("FAIL zero_guard_first got=%h exp=1", bus.r); end
`else
        checks++; if (bus.r !== 64'd0) begin errors++; $display("FAIL zero_first got=%h exp=0", bus.r); end
`endif
        w = model_next();
        for (int i = 0; i < 3; i++) begin
            request();
            w = model_next();
            checks++; if (bus.valid !== 1'b1 || bus.r !== w) begin
                errors++; $display("FAIL zero_seq[%0d] valid=%b r=%h exp=%h", i, bus.valid, bus.r, w);
            end
        end
    endtask

    initial begin
        bus.s0_initial = '0;
        bus.s1_initial = '0;
        bus.next_u64   = 1'b0;
        test_reset();
        test_single_pulse();
        test_spaced_pulses();
        test_back_to_back();
        test_load_edge_request();
        test_reset_restart();
        test_zero_seed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xoro_rand_gen_stage.md
# xoro_rand_gen_stage

Single-stage xoroshiro128+ pseudo-random number generator producing one 64-bit word per request. It is used by the decoder test infrastructure to generate random error patterns. It can be chained so that one stage's exported state seeds the next stage. Each stage holds 128 bits of state, is seeded from input ports after reset, and advances by exactly one step per accepted request.

## Interface
- `BIT_WIDTH`, default 64; word width. The algorithm is defined only for 64; other values are unsupported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `s0_initial`  in  64  seed word 0; must be stable from reset assertion through the first clock edge after release.
- `s1_initial`  in  64  seed word 1; same stability rule as `s0_initial`.
- `next_u64`  in  1  request for one new word; sampled on each rising edge.
- `r`  out  64  registered output word.
- `valid`  out  1  one-cycle pulse; `r` is valid in the same cycle.
- `s0_new`  out  64  current state word 0 (registered), used to seed a downstream stage.
- `s1_new`  out  64  current state word 1 (registered), used to seed a downstream stage.

## Operation
- Registers: `s0` and `s1` (64 bits each), `loaded` flag (1 bit), `r`, `valid`.
- **Reset asserted:** `s0`, `s1`, `r`, `valid` and `loaded` clear to 0 asynchronously.
- **LOAD state** (`loaded`=0):
  - First rising edge after release sets `s0`=`s0_initial`, `s1`=`s1_initial`, `loaded`=1.
  - `next_u64` is ignored on this edge, and `valid` stays 0.
- **RUN state** (`loaded`=1). On an edge with `next_u64`=1, all arithmetic is mod 2^64 and rotl is a 64-bit rotate-left:
  - r ← s0 + s1, with the carry out discarded.
  - t = s1 ^ s0.
  - s0 ← rotl(s0, 24) ^ t ^ (t << 16).
  - s1 ← rotl(t, 37).
  - valid ← 1.
- On a RUN edge with `next_u64`=0: state and `r` hold, and `valid` ← 0.
- `r` keeps its last value between requests.
- `s0_new` and `s1_new` always equal the `s0` and `s1` registers.
- Reset mid-sequence drops any pending output. After release the stage reloads the seeds and the sequence restarts from the first word.
- An all-zero seed locks the generator at `r`=0 unless the guard in Configuration is enabled.

## Timing
- Latency: `valid`/`r` appear in the cycle after the edge that samples `next_u64`=1, i.e. one clock.
- Throughput: one word per clock. With `next_u64` held high for N edges, `valid` stays high for N cycles with a new `r` each cycle.
- No backpressure: the consumer must capture `r` while `valid`=1.
- Minimum distance from reset release to the first accepted request is one edge, because the load edge is never a request.
- `s0_new`/`s1_new` update on the same edge as `r`.

## Configuration
- Macro `RAND_GEN_ZERO_SEED_GUARD_EN`.
- **Defined:** if `s0_initial`==0 and `s1_initial`==0 on the load edge, the stage loads `s0`=0 and `s1`=64'h0000_0000_0000_0001. Nonzero seeds load unchanged.
- **Undefined:** seeds always load verbatim, and an all-zero seed yields r=0 forever.

## Test plan
- Reset held low with seeds `s0_initial`=7646591175198567294 and `s1_initial`=15909465551595111888 -> `r`=0, `valid`=0, `s0_new`=`s1_new`=0. After release plus one edge, `s0_new`/`s1_new` equal the seeds.
- Same seeds, single `next_u64` pulse -> `valid` high for exactly 1 cycle, with `r`=5109312653084127566 (sum mod 2^64).
- Ten one-cycle pulses spaced 10 cycles apart -> exactly ten `valid` pulses. The values must match a software xoroshiro128+ model (rotations 24/16/37), and `r` holds between pulses.
- `next_u64` held high for 4 cycles -> 4 consecutive `valid` cycles with the same four words as four spaced pulses.
- `next_u64`=1 on the load edge right after reset release -> no `valid` pulse.
- Reset pulse after 3 words -> the next request returns 5109312653084127566 again.
- With `RAND_GEN_ZERO_SEED_GUARD_EN` and zero seeds -> first `r`=1.
- Without the macro and with zero seeds -> `r`=0 on every request.
